demux_dispatch: RTL
===================

DEMUX_DISPATCH -- requirements
Module: demux_dispatch

Interface
REQ-001 Parameter DATA_W, default 4, sets the payload width in bits of the input and of each output channel.
REQ-002 Parameter CNT_W, default 4, sets the width of each per-channel transfer counter.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port in_data, input, DATA_W bits: payload to dispatch.
REQ-006 Port in_sel, input, 2 bits: destination channel 0..3.
REQ-007 Port in_valid, input, 1 bit: in_data and in_sel are valid this cycle.
REQ-008 Port in_ready, output, 1 bit: the block accepts the input this cycle.
REQ-009 Ports out_data0..out_data3, output, DATA_W bits each: per-channel registered payload.
REQ-010 Port out_valid, output, 4 bits: bit k means out_data<k> holds an undelivered word.
REQ-011 Port out_ready, input, 4 bits: bit k means the consumer of channel k takes the word this cycle.
REQ-012 Port cnt_sel, input, 2 bits: selects the channel counter shown on cnt_out.
REQ-013 Port cnt_out, output, CNT_W bits: transfer count of channel cnt_sel, combinational read.

Function
REQ-014 Each channel has a one-entry buffer, a slot, holding a data register and a valid flag.
REQ-015 Input transfer: occurs when in_valid=1 and in_ready=1.
REQ-016 Output transfer on channel k: occurs when out_valid[k]=1 and out_ready[k]=1.
REQ-017 in_ready = ~out_valid[in_sel] | out_ready[in_sel]; it is combinational and independent of in_valid.
REQ-018 On an input transfer, the slot in_sel loads in_data and sets valid at the next edge, giving 1-cycle latency to out_valid.
REQ-019 Simultaneous output transfer on channel k and input transfer to k: the slot reloads with the new word and valid stays 1, with no bubble.
REQ-020 Output transfer on k with no input transfer to k: valid[k] clears at the next edge; out_data<k> holds its last value.
REQ-021 Full slot with out_ready low: in_ready=0 for that in_sel only; other channels remain independently accepting and draining.
REQ-022 While out_valid[k]=1 and no output transfer occurs, out_data<k> SHALL NOT change.
REQ-023 Each channel counter increments by 1 on every output transfer on its channel and wraps from 2^CNT_W-1 to 0.
REQ-024 Output transfers on several channels in the same cycle each update their own counter.
REQ-025 in_valid=0 causes no state change except draining by output transfers.

Reset
REQ-026 When reset=1 at an edge: out_valid=4'b0000, all out_data registers=0, and all counters=0; this overrides any concurrent transfer.
REQ-027 A word held in a slot when reset asserts is discarded and not counted; in_ready=1 in the first cycle after reset.

Structure
REQ-028 Package demux_pkg holds NUM_CH=4, SEL_W=2, and the default widths DATA_W=4 and CNT_W=4.
REQ-029 Sub-module demux_slot (load, data, drain, valid, data_out, count) is instantiated four times; the top module holds only the in_sel decode, the in_ready mux, and the cnt_sel mux.

Verification
REQ-030 Reset, then in_valid=1, in_sel=2, in_data=4'hB -> next cycle out_valid=4'b0100 and out_data2=4'hB, with the other channels unchanged.
REQ-031 Fill channel 1 with 4'hA, hold out_ready[1]=0, then offer 4'h5 to channel 1 -> in_ready=0 and out_data1 stays 4'hA; offering to channel 3 meanwhile is accepted.
REQ-032 Channel 0 full with 4'hE, out_ready[0]=1, in_sel=0, in_data=4'h4 in the same cycle -> in_ready=1, then out_valid[0]=1 and out_data0=4'h4; counter 0 becomes 1.
REQ-033 Perform 16 output transfers on channel 3 with cnt_sel=3 -> cnt_out reads 15 after the 15th transfer and 0 after the 16th (wrap).
REQ-034 Assert reset with all four slots full and counters non-zero -> next cycle out_valid=0, cnt_out=0 for every cnt_sel, and in_ready=1.
REQ-035 Drain channels 0 and 2 in the same cycle with out_ready=4'b0101 -> both valids clear and both counters increment by 1.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants for the four-channel dispatch demux.
package demux_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int DATA_W = 4;
    localparam int CNT_W  = 4;
endpackage

// File: rtl/demux_dispatch_if.sv
// Input handshake, per-channel outputs and counter read port of demux_dispatch.
interface demux_dispatch_if #(
    parameter int DATA_W = demux_pkg::DATA_W,
    parameter int CNT_W  = demux_pkg::CNT_W
);
    import demux_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic [SEL_W-1:0]  in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data0;
    logic [DATA_W-1:0] out_data1;
    logic [DATA_W-1:0] out_data2;
    logic [DATA_W-1:0] out_data3;
    logic [NUM_CH-1:0] out_valid;
    logic [NUM_CH-1:0] out_ready;
    logic [SEL_W-1:0]  cnt_sel;
    logic [CNT_W-1:0]  cnt_out;

    modport master (
        output in_data, in_sel, in_valid, out_ready, cnt_sel,
        input  in_ready, out_data0, out_data1, out_data2, out_data3, out_valid, cnt_out
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready, cnt_sel,
        output in_ready, out_data0, out_data1, out_data2, out_data3, out_valid, cnt_out
    );
endinterface

// File: rtl/demux_slot.sv
// One-entry channel buffer with a wrapping count of delivered words.
module demux_slot #(
    parameter int DATA_W = demux_pkg::DATA_W,
    parameter int CNT_W  = demux_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    input  logic              drain,
    output logic              valid,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  count
);
    logic xfer;

    assign xfer = valid & drain;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= 1'b0;
            data_out <= '0;
            count    <= '0;
        end else begin
            // a load in the same cycle as a drain keeps the slot full, no bubble
            if (load) begin
                data_out <= data;
                valid    <= 1'b1;
            end else if (xfer) begin
                valid    <= 1'b0;
            end
            if (xfer)
                count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/demux_dispatch.sv
// Routes one input word per cycle into one of four independently drained slots.
module demux_dispatch #(
    parameter int DATA_W = demux_pkg::DATA_W,
    parameter int CNT_W  = demux_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    demux_dispatch_if.slave  bus
);
    import demux_pkg::*;

    logic [NUM_CH-1:0]             load;
    logic [NUM_CH-1:0]             slot_vld;
    logic [NUM_CH-1:0][DATA_W-1:0] slot_data;
    logic [NUM_CH-1:0][CNT_W-1:0]  slot_cnt;

    // a full slot still accepts when its consumer takes the old word this cycle
    assign bus.in_ready = ~slot_vld[bus.in_sel] | bus.out_ready[bus.in_sel];

    always_comb begin
        load = '0;
        if (bus.in_valid && bus.in_ready)
            load[bus.in_sel] = 1'b1;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        demux_slot #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .load     (load[k]),
            .data     (bus.in_data),
            .drain    (bus.out_ready[k]),
            .valid    (slot_vld[k]),
            .data_out (slot_data[k]),
            .count    (slot_cnt[k])
        );
    end

    assign bus.out_valid = slot_vld;
    assign bus.out_data0 = slot_data[0];
    assign bus.out_data1 = slot_data[1];
    assign bus.out_data2 = slot_data[2];
    assign bus.out_data3 = slot_data[3];
    assign bus.cnt_out   = slot_cnt[bus.cnt_sel];
endmodule
